// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the RV32I pipeline.
//   NOP_INSTR      : canonical bubble instruction (addi x0,x0,0)
//   RESET_PC       : default PC value loaded on reset
//   fetch_state_t  : fetch FSM states (BOOT, RUN)
//   if_id_t        : IF/ID pipeline register contents
//   bubble_entry() : builds an empty (bubble) pipeline entry
// -----------------------------------------------------------------------------
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

    // A bubble carries the NOP and zeroed PCs so nothing downstream ever
    // sees stale addresses attached to a killed slot.
    function automatic if_id_t bubble_entry(input logic [31:0] nop);
        if_id_t e;
        e.instr   = nop;
        e.pc      = 32'h0000_0000;
        e.pcplus4 = 32'h0000_0000;
        e.valid   = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// Generic pipeline register holding one if_id_t entry.
// Ports:
//   clk, rst         : clock, synchronous active-low reset (loads a bubble)
//   load             : capture next_* as a valid instruction
//   bubble           : replace contents with a bubble (wins over load)
//   next_instr/pc/pcplus4 : entry to capture on load
//   instr/pc/pcplus4/valid : registered entry
// With neither load nor bubble the contents hold.
// -----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc,
    input  logic [31:0] next_pcplus4,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        valid
);
    import pipeline_pkg::*;

    if_id_t entry_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry_reg <= bubble_entry(NOP_INSTR);
        end else if (bubble) begin
            entry_reg <= bubble_entry(NOP_INSTR);
        end else if (load) begin
            entry_reg.instr   <= next_instr;
            entry_reg.pc      <= next_pc;
            entry_reg.pcplus4 <= next_pcplus4;
            entry_reg.valid   <= 1'b1;
        end
    end

    assign instr   = entry_reg.instr;
    assign pc      = entry_reg.pc;
    assign pcplus4 = entry_reg.pcplus4;
    assign valid   = entry_reg.valid;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// RV32I instruction-fetch stage: PC register, next-PC selection, boot FSM,
// delivered-instruction counter and the IF/ID pipeline register.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   stall             : hold PC and IF/ID
//   flush             : bubble IF/ID, PC still advances
//   redirect          : taken branch/JAL/JALR from execute (highest priority)
//   redirect_pc       : redirect target (low two bits ignored)
//   instr_addr        : current PC to instruction memory (combinational)
//   instr_rdata       : instruction word at instr_addr, same cycle
//   instr_d, pc_d, pcplus4_d, valid_d : IF/ID contents for decode
//   fetch_count       : number of valid instructions delivered to decode
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic [31:0] fetch_count
);
    import pipeline_pkg::*;

    fetch_state_t state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  count_reg;
    logic [31:0]  pc_plus4;
    logic         load;
    logic         bubble;

    // Targets are word aligned; the low bits of redirect_pc are discarded.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pc_plus4 = pc_reg + 32'd4;   // wraps modulo 2^32

    // IF/ID control. Priority in RUN: redirect > stall > flush > normal.
    // BOOT always inserts a bubble so decode never sees the first,
    // not-yet-settled fetch.
    always_comb begin
        load   = 1'b0;
        bubble = 1'b0;
        if (state_reg == BOOT) begin
            bubble = 1'b1;
        end else if (redirect) begin
            bubble = 1'b1;
        end else if (!stall) begin
            if (flush) begin
                bubble = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
            count_reg <= 32'd0;
        end else begin
            case (state_reg)
                BOOT: begin
                    // PC holds so RESET_PC is fetched on the first RUN edge.
                    state_reg <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        pc_reg <= {redirect_pc[31:2], 2'b00};
                    end else if (!stall) begin
                        pc_reg <= pc_plus4;
                        if (!flush) begin
                            count_reg <= count_reg + 32'd1;
                        end
                    end
                end
                default: state_reg <= BOOT;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .bubble      (bubble),
        .next_instr  (instr_rdata),
        .next_pc     (pc_reg),
        .next_pcplus4(pc_plus4),
        .instr       (instr_d),
        .pc          (pc_d),
        .pcplus4     (pcplus4_d),
        .valid       (valid_d)
    );

    assign instr_addr  = pc_reg;
    assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed scenarios plus a randomized run against a behavioural model of the
// fetch stage. The instruction memory is a pure function of the address.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [31:0] fetch_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_boot;
    logic [31:0] m_instr;
    logic [31:0] m_pc_d;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_count;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_addr (instr_addr),
        .instr_rdata(instr_rdata),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return (a ^ 32'h9E37_79B9) + 32'h0000_1000;
    endfunction

    assign instr_rdata = mem_word(instr_addr);

    // Apply one cycle of inputs, advance the model by the fetch rules, then
    // sample the DUT 1 time unit after the edge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic rd, input logic [31:0] rpc);
        rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
        if (!r) begin
            m_pc = 32'h0; m_boot = 1'b1; m_count = 32'h0;
            m_instr = 32'h13; m_pc_d = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_instr = 32'h13; m_pc_d = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (rd) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_instr = 32'h13; m_pc_d = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (s) begin
            // everything holds
        end else if (f) begin
            m_pc = m_pc + 32'd4;
            m_instr = 32'h13; m_pc_d = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc_d = m_pc;
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        $display("[TB] rst=%0b st=%0b fl=%0b rd=%0b -> addr=%h instr_d=%h pc_d=%h v=%0b cnt=%0d",
                 r, s, f, rd, instr_addr, instr_d, pc_d, valid_d, fetch_count);
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
        tests_run++;
        if ({instr_d, pc_d, pcplus4_d, valid_d} !== {32'h13, 32'h0, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_ifid: got %h/%h/%h/%0b want 00000013/0/0/0",
                     instr_d, pc_d, pcplus4_d, valid_d);
        end
        tests_run++;
        if ({instr_addr, fetch_count} !== {32'h0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_pc_count: got addr=%h cnt=%0d want 0/0", instr_addr, fetch_count);
        end
    endtask

    task automatic test_boot;
        // BOOT edge: controls are ignored, PC holds, bubble
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        tests_run++;
        if ({valid_d, instr_addr} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL boot_edge1: got v=%0b addr=%h want v=0 addr=0", valid_d, instr_addr);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if ({instr_d, pc_d, pcplus4_d, valid_d} !== {32'h0050_0093, 32'h0, 32'h4, 1'b1}) begin
            tests_failed++;
            $display("FAIL boot_edge2: got %h/%h/%h/%0b want 00500093/0/4/1",
                     instr_d, pc_d, pcplus4_d, valid_d);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if ({instr_d, pc_d, fetch_count} !== {32'h0010_0113, 32'h4, 32'd2}) begin
            tests_failed++;
            $display("FAIL boot_edge3: got %h/%h cnt=%0d want 00100113/4 cnt=2",
                     instr_d, pc_d, fetch_count);
        end
    endtask

    task automatic test_stall;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);   // pc_d = 8
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, (i == 1), 1'b0, 32'h0);
            tests_run++;
            if ({instr_addr, pc_d, valid_d, fetch_count} !== {32'hC, 32'h8, 1'b1, 32'd3}) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got addr=%h pc_d=%h v=%0b cnt=%0d want C/8/1/3",
                         i, instr_addr, pc_d, valid_d, fetch_count);
            end
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if ({pc_d, pcplus4_d, fetch_count} !== {32'hC, 32'h10, 32'd4}) begin
            tests_failed++;
            $display("FAIL stall_release: got pc_d=%h pc4=%h cnt=%0d want C/10/4",
                     pc_d, pcplus4_d, fetch_count);
        end
    endtask

    task automatic test_flush;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);   // PC = 0x10
        tests_run++;
        if ({valid_d, instr_d, pc_d, instr_addr, fetch_count} !==
            {1'b0, 32'h13, 32'h0, 32'h14, 32'd4}) begin
            tests_failed++;
            $display("FAIL flush: got v=%0b instr=%h pc_d=%h addr=%h cnt=%0d want 0/13/0/14/4",
                     valid_d, instr_d, pc_d, instr_addr, fetch_count);
        end
    endtask

    task automatic test_redirect;
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        tests_run++;
        if ({instr_addr, valid_d} !== {32'h40, 1'b0}) begin
            tests_failed++;
            $display("FAIL redirect_stall: got addr=%h v=%0b want 40/0", instr_addr, valid_d);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if ({pc_d, valid_d, instr_d} !== {32'h40, 1'b1, mem_word(32'h40)}) begin
            tests_failed++;
            $display("FAIL redirect_target: got pc_d=%h v=%0b instr=%h want 40/1/%h",
                     pc_d, valid_d, instr_d, mem_word(32'h40));
        end
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h43);
        tests_run++;
        if ({instr_addr, valid_d} !== {32'h40, 1'b0}) begin
            tests_failed++;
            $display("FAIL redirect_align: got addr=%h v=%0b want 40/0", instr_addr, valid_d);
        end
    endtask

    task automatic test_wrap_and_midreset;
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if ({pc_d, pcplus4_d, instr_addr, valid_d} !== {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1}) begin
            tests_failed++;
            $display("FAIL pc_wrap: got pc_d=%h pc4=%h addr=%h v=%0b want FFFFFFFC/0/0/1",
                     pc_d, pcplus4_d, instr_addr, valid_d);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h120);
        tests_run++;
        if ({instr_addr, valid_d, fetch_count, instr_d} !== {32'h0, 1'b0, 32'd0, 32'h13}) begin
            tests_failed++;
            $display("FAIL midrun_reset: got addr=%h v=%0b cnt=%0d instr=%h want 0/0/0/13",
                     instr_addr, valid_d, fetch_count, instr_d);
        end
        // BOOT again after reset: first edge must be a bubble
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tests_run++;
        if ({valid_d, instr_addr} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reboot: got v=%0b addr=%h want 0/0", valid_d, instr_addr);
        end
    endtask

    task automatic test_random;
        logic r, s, f, rd;
        logic [31:0] rpc;
        for (int i = 0; i < 300; i++) begin
            r   = ($urandom_range(0, 39) != 0);
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 5) == 0);
            rd  = ($urandom_range(0, 7) == 0);
            rpc = $urandom;
            if (i % 50 == 7) rpc = 32'hFFFF_FFF8 | {30'h0, rpc[1:0]};
            step(r, s, f, rd, rpc);
            tests_run++;
            if ({instr_addr, instr_d, pc_d, pcplus4_d, valid_d, fetch_count} !==
                {m_pc, m_instr, m_pc_d, m_pc4, m_valid, m_count}) begin
                tests_failed++;
                $display("FAIL random[%0d]: got addr=%h instr=%h pc_d=%h pc4=%h v=%0b cnt=%0d want %h/%h/%h/%h/%0b/%0d",
                         i, instr_addr, instr_d, pc_d, pcplus4_d, valid_d, fetch_count,
                         m_pc, m_instr, m_pc_d, m_pc4, m_valid, m_count);
            end
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        m_pc = 32'h0; m_boot = 1'b1; m_count = 32'h0;
        m_instr = 32'h13; m_pc_d = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        #2;
        test_reset();
        test_boot();
        test_stall();
        test_flush();
        test_redirect();
        test_wrap_and_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
